pipe_link: RTL
==============

# pipe_link

Parametrised inter-stage link for the five-stage core (IF→ID→EX→MA→WB). It replaces the bare syn/ack wire pair between stages with a 2^ADDR_L-entry FIFO carrying a DATA_L-bit stage payload. It adds a synchronous flush so a taken jump/branch from EX can discard wrong-path entries. One instance sits between each pair of adjacent pipe stages; payload packing is owned by the stages.

## Interface
- DATA_L, 64, payload width in bits (≥1)
- ADDR_L, 1, log2 of entry count; depth = 2^ADDR_L (ADDR_L ≥ 1)
- LINK_ID, 0, instance tag for debug display only; no functional effect

- clk  input  1  clock; all state updates on posedge
- rst  input  1  reset, asynchronous, active-high
- in_syn  input  1  upstream stage offers in_data
- in_ack  output  1  link accepts in_data this cycle
- in_data  input  DATA_L  upstream payload
- out_syn  output  1  out_data valid for downstream
- out_ack  input  1  downstream consumes out_data this cycle
- out_data  output  DATA_L  head payload
- flush  input  1  discard all contents (EX jump/branch taken)
- count  output  ADDR_L+1  entries currently held
- em  output  1  count == 0
- fu  output  1  count == 2^ADDR_L

## Operation
- Push = in_syn && in_ack; pop = out_syn && out_ack. Each occurs only when both signals are high in the same cycle. Neither side may withdraw syn/data on the strength of the other's signal.
- Storage: circular array of 2^ADDR_L entries with ADDR_L-bit write/read pointers. Pointers wrap modulo 2^ADDR_L naturally; full/empty come from count, not from pointer compare.
- in_ack = !fu && !flush. No combinational path from out_ack to in_ack. A full link accepts nothing even when a pop occurs that cycle.
- out_syn = !em && !flush; out_data = entry at read pointer (zero when em, non-bypass build).
- Push and pop in the same cycle: count unchanged, both pointers advance.
- flush: highest priority. That cycle there is no push or pop (in_ack = out_syn = 0). At the edge, pointers are cleared to 0, count to 0 and array contents are left as is. The upstream stage must re-present any offer after flush drops.
- Flush while empty or full: same result, count 0.

## Timing
- Reset (async, immediate): count 0, em 1, fu 0, in_ack 1, out_syn 0, out_data 0, pointers 0.
- Latency (non-bypass): a payload pushed at edge N is visible on out_data with out_syn=1 after edge N; earliest pop is in cycle N+1.
- Throughput: one push and one pop per cycle in steady state for ADDR_L ≥ 1.
- count, em and fu update on the edge following a push/pop/flush. They are registered-derived, not combinational from syn/ack.
- rst asserted mid-transfer: in-flight push/pop is lost; outputs take reset values in the same cycle.

## Configuration
- PIPE_LINK_BYPASS_EN defined: when em && !flush, out_syn = in_syn and out_data = in_data combinationally. If out_ack is also high, the payload passes through with zero latency, is not written, and count stays 0. If out_ack is low, it is pushed normally. This adds a combinational in→out path; in_ack logic is unchanged.
- Not defined: no bypass; minimum latency one cycle as above; no combinational path from in_* to out_*.

## Test plan
- Reset then fill: DATA_L=64, ADDR_L=2, out_ack=0, push 0x1,0x2,0x3,0x4 on consecutive cycles. Expect count 4, fu 1, in_ack 0. Offer 0x5, which is not accepted.
- Drain order: from the full state, out_ack=1 for 4 cycles. Expect out_data 0x1,0x2,0x3,0x4 in order, then em 1, out_syn 0.
- Simultaneous push/pop and wrap: with count=2, hold in_syn=out_ack=1 for 10 cycles using incrementing data. Expect count to remain 2 and output to lag input by exactly 2 entries across pointer wrap.
- Full plus pop: with fu=1, in_syn=1 and out_ack=1. Expect in_ack 0 and only the pop to occur, then count 3. Next cycle in_ack 1.
- Flush: with count 3 and flush=1 together with in_syn=1 (0xAA), expect in_ack 0 and out_syn 0. After the edge, count 0, em 1, and 0xAA absent from later output.
- Bypass (PIPE_LINK_BYPASS_EN): em=1, in_syn=out_ack=1, in_data 0x55. Expect out_syn 1 and out_data 0x55 in the same cycle, with count remaining 0. Without the macro, out_syn stays 0 that cycle and 0x55 appears next cycle.

Source files
------------

// File: rtl/pipe_link.sv
// pipe_link: 2^ADDR_L-entry FIFO link between adjacent pipe stages, with syn/ack handshake and synchronous flush.
// Define PIPE_LINK_BYPASS_EN to let a payload pass straight through an empty link in the same cycle.
module pipe_link #(
    parameter int DATA_L  = 64,
    parameter int ADDR_L  = 1,
    parameter int LINK_ID = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_syn,
    output logic              in_ack,
    input  logic [DATA_L-1:0] in_data,
    output logic              out_syn,
    input  logic              out_ack,
    output logic [DATA_L-1:0] out_data,
    input  logic              flush,
    output logic [ADDR_L:0]   count,
    output logic              em,
    output logic              fu
);

    localparam logic [ADDR_L:0] DEPTH = {1'b1, {ADDR_L{1'b0}}};

    if (DATA_L < 1 || ADDR_L < 1 || LINK_ID < 0) begin : g_bad_params
        $error("pipe_link: DATA_L and ADDR_L must be >= 1, LINK_ID >= 0");
    end

    logic [DATA_L-1:0] mem [0:(1 << ADDR_L)-1];
    logic [ADDR_L-1:0] wr_ptr;
    logic [ADDR_L-1:0] rd_ptr;
    logic              push;
    logic              pop;
    logic              wr_en;
    logic              rd_en;

    // Flags come from the registered count only, never from the handshake inputs.
    assign em     = (count == '0);
    assign fu     = (count == DEPTH);
    assign in_ack = !fu && !flush;
    assign push   = in_syn && in_ack;
    assign pop    = out_syn && out_ack;

`ifdef PIPE_LINK_BYPASS_EN
    logic bypass;

    assign bypass   = em && !flush;
    assign out_syn  = bypass ? in_syn : (!em && !flush);
    assign out_data = bypass ? in_data : (em ? '0 : mem[rd_ptr]);
    // A payload consumed straight through an empty link is never stored.
    assign wr_en    = push && !(bypass && out_ack);
    assign rd_en    = pop && !em;
`else
    assign out_syn  = !em && !flush;
    assign out_data = em ? '0 : mem[rd_ptr];
    assign wr_en    = push;
    assign rd_en    = pop;
`endif

    // NOTE: storage has no reset; pointers and count alone define which entries are live.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + ADDR_L'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + ADDR_L'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + (ADDR_L+1)'(1);
                2'b01:   count <= count - (ADDR_L+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
